// File: rtl/timer_pkg.sv
// Shared constants for the 16-bit timer: control-register field positions,
// count-source encodings and register reset values.
package timer_pkg;

    localparam int CON_EN       = 0;
    localparam int CON_CSEL_LSB = 1;
    localparam int CON_CSEL_MSB = 3;
    localparam int CON_PSC_LSB  = 4;
    localparam int CON_PSC_MSB  = 6;
    localparam int CON_ONESHOT  = 7;
    localparam int CON_IE       = 8;
    localparam int CON_CAPE     = 9;
    localparam int CON_CAPEDGE  = 10;
    localparam int CON_CAPF     = 14;
    localparam int CON_OVF      = 15;

    localparam logic [15:0] PRD_RST = 16'hFFFF;

    typedef enum logic [2:0] {
        CSEL_SYS  = 3'd0,
        CSEL_SRC1 = 3'd1,
        CSEL_SRC2 = 3'd2,
        CSEL_SRC3 = 3'd3,
        CSEL_SRC4 = 3'd4
    } csel_e;

    // Terminal value of the prescaler for a divide-by-2^psc setting.
    function automatic logic [7:0] psc_limit(input logic [2:0] psc);
        logic [8:0] w_lim;
        w_lim = (9'd1 << psc) - 9'd1;
        return w_lim[7:0];
    endfunction

endpackage

// File: rtl/timer_edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a one-cycle
// edge detector; i_fall selects falling (1) or rising (0) edges.
module timer_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    input  logic i_fall,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_edge = i_fall ? (r_s3 & ~r_s2) : (r_s2 & ~r_s3);

endmodule

// File: rtl/timer_16b.sv
// 16-bit period timer with selectable count source and prescaler.
// Input capture on icsrc is built only when TMR_CAPTURE_EN is defined.
module timer_16b
    import timer_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tmr_con_wr,
    input  logic        tmr_prd_wr,
    input  logic        tmr_cnt_wr,
    input  logic [15:0] icb_wdat,
    input  logic        clkisrc1,
    input  logic        clkisrc2,
    input  logic        clkisrc3,
    input  logic        clkisrc4,
    input  logic        icsrc,
    output logic [15:0] tmr_con,
    output logic [15:0] tmr_prd,
    output logic [15:0] tmr_cnt,
    output logic        tmr_ovf,
    output logic        tmr_int
);

    logic        r_en;
    logic [2:0]  r_csel;
    logic [2:0]  r_psc_sel;
    logic        r_oneshot;
    logic        r_ie;
    logic        r_ovf_flag;
    logic        r_ovf_pulse;
    logic [15:0] r_cnt;
    logic [15:0] r_prd;
    logic [7:0]  r_psc;

    logic [3:0]  w_src_in;
    logic [3:0]  w_src_edge;
    logic        w_src_tick;
    logic        w_cnt_tick;
    logic        w_match;
    logic        w_wrap;
    logic        w_cap_mode;
    logic        w_cap_evt;
    logic        w_cape;
    logic        w_capedge;
    logic        w_capf;
    logic        w_unused;

    assign w_src_in = {clkisrc4, clkisrc3, clkisrc2, clkisrc1};

    for (genvar g = 0; g < 4; g++) begin : g_src_sync
        timer_edge_sync u_sync (
            .i_clk  (sys_clk),
            .i_rst  (sys_rst),
            .i_async(w_src_in[g]),
            .i_fall (1'b0),
            .o_edge (w_src_edge[g])
        );
    end

    always_comb begin
        w_src_tick = 1'b0;
        case (r_csel)
            CSEL_SYS:  w_src_tick = 1'b1;
            CSEL_SRC1: w_src_tick = w_src_edge[0];
            CSEL_SRC2: w_src_tick = w_src_edge[1];
            CSEL_SRC3: w_src_tick = w_src_edge[2];
            CSEL_SRC4: w_src_tick = w_src_edge[3];
            default:   w_src_tick = 1'b0;
        endcase
    end

    assign w_cnt_tick = r_en & w_src_tick & (r_psc == psc_limit(r_psc_sel));
    // In capture mode tmr_prd holds the captured value, so the wrap point is fixed at FFFF.
    assign w_match    = w_cap_mode ? (r_cnt == 16'hFFFF) : (r_cnt == r_prd);
    assign w_wrap     = w_cnt_tick & ~tmr_cnt_wr & w_match;

`ifdef TMR_CAPTURE_EN
    logic r_cape;
    logic r_capedge;
    logic r_capf;
    logic w_ic_edge;

    timer_edge_sync u_ic_sync (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .i_async(icsrc),
        .i_fall (r_capedge),
        .o_edge (w_ic_edge)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cape    <= 1'b0;
            r_capedge <= 1'b0;
            r_capf    <= 1'b0;
        end else begin
            if (tmr_con_wr) begin
                r_cape    <= icb_wdat[CON_CAPE];
                r_capedge <= icb_wdat[CON_CAPEDGE];
            end
            r_capf <= (r_capf & ~(tmr_con_wr & icb_wdat[CON_CAPF])) | w_cap_evt;
        end
    end

    assign w_cape     = r_cape;
    assign w_capedge  = r_capedge;
    assign w_capf     = r_capf;
    assign w_cap_mode = r_cape;
    assign w_cap_evt  = r_cape & w_ic_edge;
    assign w_unused   = ^icb_wdat[13:11];
`else
    assign w_cape     = 1'b0;
    assign w_capedge  = 1'b0;
    assign w_capf     = 1'b0;
    assign w_cap_mode = 1'b0;
    assign w_cap_evt  = 1'b0;
    assign w_unused   = ^{icb_wdat[14:9], icsrc};
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_en        <= 1'b0;
            r_csel      <= 3'd0;
            r_psc_sel   <= 3'd0;
            r_oneshot   <= 1'b0;
            r_ie        <= 1'b0;
            r_ovf_flag  <= 1'b0;
            r_ovf_pulse <= 1'b0;
            r_cnt       <= 16'h0000;
            r_prd       <= PRD_RST;
            r_psc       <= 8'h00;
        end else begin
            r_ovf_pulse <= w_wrap;
            if (tmr_con_wr) begin
                r_en      <= icb_wdat[CON_EN];
                r_csel    <= icb_wdat[CON_CSEL_MSB:CON_CSEL_LSB];
                r_psc_sel <= icb_wdat[CON_PSC_MSB:CON_PSC_LSB];
                r_oneshot <= icb_wdat[CON_ONESHOT];
                r_ie      <= icb_wdat[CON_IE];
            end else if (w_wrap && r_oneshot) begin
                r_en <= 1'b0;
            end
            r_ovf_flag <= (r_ovf_flag & ~(tmr_con_wr & icb_wdat[CON_OVF])) | w_wrap;

            if (tmr_cnt_wr) begin
                r_cnt <= icb_wdat;
                r_psc <= 8'h00;
            end else if (r_en && w_src_tick) begin
                if (w_cnt_tick) begin
                    r_psc <= 8'h00;
                    r_cnt <= w_match ? 16'h0000 : r_cnt + 16'd1;
                end else begin
                    r_psc <= r_psc + 8'd1;
                end
            end

            if (tmr_prd_wr) begin
                r_prd <= icb_wdat;
            end else if (w_cap_evt) begin
                r_prd <= r_cnt;
            end
        end
    end

    assign tmr_con = {r_ovf_flag, w_capf, 3'b000, w_capedge, w_cape, r_ie,
                      r_oneshot, r_psc_sel, r_csel, r_en};
    assign tmr_prd = r_prd;
    assign tmr_cnt = r_cnt;
    // Gated by reset so nothing leaks out in the cycle reset is first applied.
    assign tmr_ovf = r_ovf_pulse & ~sys_rst;
    assign tmr_int = r_ie & (r_ovf_flag | w_capf) & ~sys_rst;

endmodule

// File: tb/tb_timer_16b.sv
// Self-checking bench for timer_16b: behavioural model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_timer_16b;

`ifdef TMR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        sys_clk;
    logic        sys_rst;
    logic        tmr_con_wr;
    logic        tmr_prd_wr;
    logic        tmr_cnt_wr;
    logic [15:0] icb_wdat;
    logic        clkisrc1;
    logic        clkisrc2;
    logic        clkisrc3;
    logic        clkisrc4;
    logic        icsrc;
    logic [15:0] tmr_con;
    logic [15:0] tmr_prd;
    logic [15:0] tmr_cnt;
    logic        tmr_ovf;
    logic        tmr_int;

    timer_16b dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tmr_con_wr(tmr_con_wr),
        .tmr_prd_wr(tmr_prd_wr),
        .tmr_cnt_wr(tmr_cnt_wr),
        .icb_wdat  (icb_wdat),
        .clkisrc1  (clkisrc1),
        .clkisrc2  (clkisrc2),
        .clkisrc3  (clkisrc3),
        .clkisrc4  (clkisrc4),
        .icsrc     (icsrc),
        .tmr_con   (tmr_con),
        .tmr_prd   (tmr_prd),
        .tmr_cnt   (tmr_cnt),
        .tmr_ovf   (tmr_ovf),
        .tmr_int   (tmr_int)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_on   = 1'b0;

    // Model state
    bit          m_en, m_oneshot, m_ie, m_cape, m_capedge, m_capf, m_ovf, m_pulse;
    logic [2:0]  m_csel, m_psc;
    logic [15:0] m_cnt, m_prd;
    int          m_pre;
    bit   [2:0]  m_h [5];
    bit   [4:0]  mt_rise, mt_fall, mt_smp;
    bit          mt_src, mt_wrap, mt_capev, mt_cap_mode, mt_stop;
    int          mt_div;
    logic [15:0] mt_old;

    logic [15:0] seq_a [5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000};
    logic [15:0] seq_os [9] = '{16'h0000, 16'h0001, 16'h0002, 16'h0000, 16'h0000,
                                16'h0000, 16'h0000, 16'h0000, 16'h0000};

    always @(posedge sys_clk) begin
        mt_smp = {icsrc, clkisrc4, clkisrc3, clkisrc2, clkisrc1};
        if (sys_rst) begin
            m_en = 0; m_oneshot = 0; m_ie = 0; m_cape = 0; m_capedge = 0;
            m_capf = 0; m_ovf = 0; m_pulse = 0;
            m_csel = 3'd0; m_psc = 3'd0; m_cnt = 16'h0000; m_prd = 16'hFFFF; m_pre = 0;
            for (int j = 0; j < 5; j++) m_h[j] = 3'b000;
        end else begin
            // an input edge seen by the sampling flops two edges ago acts now
            for (int j = 0; j < 5; j++) begin
                mt_rise[j] = m_h[j][1] & ~m_h[j][2];
                mt_fall[j] = ~m_h[j][1] & m_h[j][2];
            end
            if (m_csel == 3'd0)      mt_src = 1'b1;
            else if (m_csel <= 3'd4) mt_src = mt_rise[int'(m_csel) - 1];
            else                     mt_src = 1'b0;
            mt_div      = 1 << m_psc;
            mt_old      = m_cnt;
            mt_wrap     = 1'b0;
            mt_cap_mode = CAP && m_cape;
            mt_capev    = CAP && m_cape && (m_capedge ? mt_fall[4] : mt_rise[4]);
            if (tmr_cnt_wr) begin
                m_cnt = icb_wdat;
                m_pre = 0;
            end else if (m_en && mt_src) begin
                m_pre = m_pre + 1;
                if (m_pre == mt_div) begin
                    m_pre = 0;
                    if (m_cnt == (mt_cap_mode ? 16'hFFFF : m_prd)) begin
                        m_cnt   = 16'h0000;
                        mt_wrap = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 16'd1;
                    end
                end
            end
            if (tmr_prd_wr)    m_prd = icb_wdat;
            else if (mt_capev) m_prd = mt_old;
            mt_stop = mt_wrap && m_oneshot;
            m_ovf   = (m_ovf && !(tmr_con_wr && icb_wdat[15])) || mt_wrap;
            m_capf  = CAP && ((m_capf && !(tmr_con_wr && icb_wdat[14])) || mt_capev);
            if (tmr_con_wr) begin
                m_en      = icb_wdat[0];
                m_csel    = icb_wdat[3:1];
                m_psc     = icb_wdat[6:4];
                m_oneshot = icb_wdat[7];
                m_ie      = icb_wdat[8];
                m_cape    = CAP && icb_wdat[9];
                m_capedge = CAP && icb_wdat[10];
            end else if (mt_stop) begin
                m_en = 1'b0;
            end
            m_pulse = mt_wrap;
            for (int j = 0; j < 5; j++) m_h[j] = {m_h[j][1:0], mt_smp[j]};
        end
    end

    function automatic logic [15:0] exp_con();
        return {m_ovf, m_capf, 3'b000, m_capedge, m_cape, m_ie, m_oneshot, m_psc, m_csel, m_en};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge sys_clk);
            if (cmp_on) begin
                check("model con", tmr_con, exp_con());
                check("model prd", tmr_prd, m_prd);
                check("model cnt", tmr_cnt, m_cnt);
                check("model ovf", {15'd0, tmr_ovf}, {15'd0, m_pulse & ~sys_rst});
                check("model int", {15'd0, tmr_int}, {15'd0, m_ie & (m_ovf | m_capf) & ~sys_rst});
            end
        end
    endtask

    task automatic wr(input bit c, input bit p, input bit n, input logic [15:0] d);
        @(posedge sys_clk); #1;
        tmr_con_wr = c; tmr_prd_wr = p; tmr_cnt_wr = n; icb_wdat = d;
        @(posedge sys_clk); #1;
        tmr_con_wr = 0; tmr_prd_wr = 0; tmr_cnt_wr = 0; icb_wdat = 16'h0000;
    endtask

    task automatic setup(input logic [15:0] prd, input logic [15:0] con);
        wr(1, 0, 0, 16'hC000);
        wr(0, 0, 1, 16'h0000);
        wr(0, 1, 0, prd);
        wr(1, 0, 0, con);
    endtask

    int first_ovf, second_ovf, ovf_cnt;

    initial begin
        sys_rst = 1; tmr_con_wr = 0; tmr_prd_wr = 0; tmr_cnt_wr = 0; icb_wdat = 16'h0000;
        clkisrc1 = 0; clkisrc2 = 0; clkisrc3 = 0; clkisrc4 = 0; icsrc = 0;
        fork
            compare_loop();
        join_none
        @(posedge sys_clk); #1;
        cmp_on = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 0;

        // reset values, and still quiet the cycle after release
        @(negedge sys_clk);
        check("rst con", tmr_con, 16'h0000);
        check("rst prd", tmr_prd, 16'hFFFF);
        check("rst cnt", tmr_cnt, 16'h0000);
        check("rst int", {15'd0, tmr_int}, 16'h0000);
        check("rst ovf", {15'd0, tmr_ovf}, 16'h0000);

        // period 3 on sys_clk
        setup(16'h0003, 16'h0101);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check("p3 cnt", tmr_cnt, seq_a[i]);
            check("p3 ovf", {15'd0, tmr_ovf}, (i == 4) ? 16'h0001 : 16'h0000);
        end
        check("p3 con", tmr_con, 16'h8101);
        check("p3 int", {15'd0, tmr_int}, 16'h0001);
        wr(1, 0, 0, 16'h8101);
        @(negedge sys_clk);
        check("w1c con", tmr_con, 16'h0101);
        check("w1c int", {15'd0, tmr_int}, 16'h0000);

        // prescale by 4, period 1
        setup(16'h0001, 16'h0021);
        first_ovf = -1; second_ovf = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (tmr_ovf) begin
                if (first_ovf < 0) first_ovf = k;
                else if (second_ovf < 0) second_ovf = k;
            end
            if (k == 3) check("psc cnt k3", tmr_cnt, 16'h0000);
            if (k == 4) check("psc cnt k4", tmr_cnt, 16'h0001);
        end
        check("psc ovf1", first_ovf[15:0], 16'd8);
        check("psc ovf2", second_ovf[15:0], 16'd16);

        // external source 2, source 1 toggling alongside
        setup(16'hFFFF, 16'h0005);
        for (int c = 0; c < 40; c++) begin
            @(posedge sys_clk); #1;
            clkisrc1 = ~clkisrc1;
            clkisrc2 = ((c % 10) < 5);
            @(negedge sys_clk);
            if ((c % 10) == 2) check("src2 before", tmr_cnt, 16'(c / 10));
            if ((c % 10) == 3) check("src2 after", tmr_cnt, 16'(c / 10 + 1));
        end
        clkisrc1 = 0; clkisrc2 = 0;

        // one-shot, period 2
        setup(16'h0002, 16'h0081);
        for (int k = 0; k < 9; k++) begin
            @(negedge sys_clk);
            check("os cnt", tmr_cnt, seq_os[k]);
            if (k == 3) check("os ovf", {15'd0, tmr_ovf}, 16'h0001);
            if (k >= 3) check("os con", tmr_con, 16'h8080);
        end

        // period 0: overflow on every tick
        setup(16'h0000, 16'h0001);
        @(negedge sys_clk);
        ovf_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            if (tmr_ovf) ovf_cnt++;
        end
        check("p0 ovf count", ovf_cnt[15:0], 16'd6);
        check("p0 cnt", tmr_cnt, 16'h0000);
        wr(1, 0, 0, 16'h8001);
        @(negedge sys_clk);
        check("w1c vs set", tmr_con, 16'h8001);
        wr(0, 0, 1, 16'h0005);
        @(negedge sys_clk);
        check("cnt wr cnt", tmr_cnt, 16'h0005);
        check("cnt wr ovf", {15'd0, tmr_ovf}, 16'h0000);
        wr(0, 1, 1, 16'h0010);
        @(negedge sys_clk);
        check("dual cnt", tmr_cnt, 16'h0010);
        check("dual prd", tmr_prd, 16'h0010);

        // reset while counting
        @(posedge sys_clk); #1 sys_rst = 1;
        @(negedge sys_clk);
        check("mid rst ovf", {15'd0, tmr_ovf}, 16'h0000);
        check("mid rst int", {15'd0, tmr_int}, 16'h0000);
        @(posedge sys_clk); #1 sys_rst = 0;
        @(negedge sys_clk);
        check("post rst cnt", tmr_cnt, 16'h0000);
        check("post rst con", tmr_con, 16'h0000);
        check("post rst prd", tmr_prd, 16'hFFFF);
        check("post rst ovf", {15'd0, tmr_ovf}, 16'h0000);

`ifdef TMR_CAPTURE_EN
        wr(1, 0, 0, 16'hC000);
        wr(0, 0, 1, 16'h0038);
        wr(1, 0, 0, 16'h0201);
        for (int k = 0; k < 9; k++) @(negedge sys_clk);
        check("cap cnt", tmr_cnt, 16'h0040);
        icsrc = 1;
        repeat (3) @(negedge sys_clk);
        check("cap prd", tmr_prd, 16'h0042);
        check("cap con", tmr_con, 16'h4201);
        wr(0, 0, 1, 16'hFFFE);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("cap ffff", tmr_cnt, 16'hFFFF);
        @(negedge sys_clk);
        check("cap wrap cnt", tmr_cnt, 16'h0000);
        check("cap wrap ovf", {15'd0, tmr_ovf}, 16'h0001);
        icsrc = 0;
`else
        wr(1, 0, 0, 16'h0601);
        icsrc = 1;
        repeat (4) @(negedge sys_clk);
        check("nocap con", tmr_con, 16'h0001);
        icsrc = 0;
`endif
        repeat (3) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/timer_16b.md
TIMER_16B -- requirements
Module: timer_16b

Interface
REQ-001 SHALL have port sys_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports tmr_con_wr, tmr_prd_wr and tmr_cnt_wr, inputs, 1 bit each: write strobes for the control, period and counter registers.
REQ-004 SHALL have port icb_wdat, input, 16 bits: shared write-data bus for all three strobes.
REQ-005 SHALL have ports clkisrc1, clkisrc2, clkisrc3 and clkisrc4, inputs, 1 bit each: asynchronous external count sources.
REQ-006 SHALL have port icsrc, input, 1 bit: asynchronous input-capture source.
REQ-007 SHALL have ports tmr_con, tmr_prd and tmr_cnt, outputs, 16 bits each: register read-back.
REQ-008 SHALL have port tmr_ovf, output, 1 bit: one-cycle pulse on period match.
REQ-009 SHALL have port tmr_int, output, 1 bit: level interrupt request.

Function
REQ-010 SHALL implement tmr_con with these fields:
- [0] EN: count enable.
- [3:1] CSEL: 0 = sys_clk, 1-4 = clkisrc1-4, 5-7 = no count.
- [6:4] PSC: prescale by 2^PSC.
- [7] ONESHOT.
- [8] IE.
- [9] CAPE.
- [10] CAPEDGE: 0 = rising, 1 = falling.
- [13:11] reserved, read 0.
- [14] CAPF.
- [15] OVF.
REQ-011 SHALL, on tmr_con_wr, load bits [10:0] from icb_wdat and clear CAPF/OVF where the icb_wdat bit is 1 (write-1-to-clear); a write of 0 leaves a flag unchanged.
REQ-012 SHALL synchronize each clkisrcN with 2 flops followed by rising-edge detect, giving a one-cycle source tick 3 sys_clk cycles after the external edge.
REQ-013 SHALL produce a source tick every cycle when CSEL=0.
REQ-014 SHALL use an 8-bit prescaler that counts source ticks while EN=1 and issues a count tick when it reaches 2^PSC-1, then returns to 0; PSC=0 passes every source tick through.
REQ-015 SHALL, on a count tick, load tmr_cnt with 0 if tmr_cnt==tmr_prd (normal mode), otherwise increment tmr_cnt.
REQ-016 SHALL, on the wrap in REQ-015, pulse tmr_ovf for one cycle in the same cycle tmr_cnt becomes 0, and set OVF.
REQ-017 SHALL treat tmr_prd=0 as a match on every count tick: tmr_cnt stays 0 and tmr_ovf pulses on every count tick.
REQ-018 SHALL, when ONESHOT=1, clear EN in the same cycle as the match.
REQ-019 SHALL, on tmr_cnt_wr, load tmr_cnt from icb_wdat and clear the prescaler, overriding any count tick in that cycle.
REQ-020 SHALL, on tmr_prd_wr, load tmr_prd from icb_wdat.
REQ-021 SHALL, when multiple strobes are asserted in one cycle, apply each independently from the same icb_wdat.
REQ-022 SHALL drive tmr_int = IE & (OVF | CAPF), registered-free and combinational from the flags.
REQ-023 SHALL, when a hardware flag set coincides with a W1C of the same flag, leave the flag set.
REQ-024 SHALL make EN=0 freeze tmr_cnt and the prescaler while writes remain accepted.

Reset
REQ-025 SHALL, on sys_rst=1 at a clock edge, set tmr_con=0, tmr_cnt=0, tmr_prd=16'hFFFF, prescaler=0 and synchronizers=0.
REQ-026 SHALL hold tmr_ovf=0 and tmr_int=0 during reset and in the cycle after reset is released.
REQ-027 SHALL, on reset asserted mid-count, abort the count immediately with no tmr_ovf pulse.

Configuration
REQ-028 SHALL, with TMR_CAPTURE_EN defined, implement capture when CAPE=1:
- icsrc is synchronized with 2 flops and edge-detected per CAPEDGE.
- On a detected edge, tmr_cnt is copied to tmr_prd and CAPF is set.
- Period match is disabled; the counter wraps from FFFF to 0, pulses tmr_ovf and sets OVF.
REQ-029 SHALL, with TMR_CAPTURE_EN not defined, read CAPE, CAPEDGE and CAPF as 0, ignore icsrc, and exclude the capture logic from synthesis.

Structure
REQ-030 SHALL place in package timer_pkg the tmr_con bit-position constants, the CSEL encodings and the reset value of tmr_prd.
REQ-031 SHALL use one sub-module, timer_edge_sync (2-flop sync plus edge detect with a selectable edge), instantiated for each clkisrcN and for icsrc.

Verification
REQ-032 SHALL cover this scenario: reset, then check tmr_con=0000, tmr_prd=FFFF, tmr_cnt=0000, tmr_int=0.
REQ-033 SHALL cover this scenario: tmr_prd=0003, tmr_con=0101 (EN, IE, sys_clk, PSC=0) -> tmr_cnt sequence 1,2,3,0; tmr_ovf pulses on the 4th tick; OVF=1 and tmr_int=1; then write tmr_con=8101 -> OVF=0 and tmr_int=0.
REQ-034 SHALL cover this scenario: PSC=2, CSEL=0, tmr_prd=0001 -> tmr_cnt increments every 4 cycles; tmr_ovf every 8 cycles.
REQ-035 SHALL cover this scenario: CSEL=2, clkisrc2 toggled at 1/10 the sys_clk rate -> one increment per clkisrc2 rising edge, 3 cycles after the edge; clkisrc1 activity has no effect.
REQ-036 SHALL cover this scenario: ONESHOT with tmr_prd=0002 -> counter wraps once to 0, EN reads 0, and tmr_cnt stays 0.
REQ-037 SHALL cover this scenario, with TMR_CAPTURE_EN defined: CAPE=1, rising edge on icsrc while tmr_cnt=0x0040 -> tmr_prd=0x0040 (±sync latency, checked exactly against the model), CAPF=1.
